// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared constants and types for the instruction-side AXI read bridge.
package inst_axi_rd_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_BYTE  = 3'd0;
    localparam logic [2:0] AXI_SIZE_HALF  = 3'd1;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } rd_state_t;

    // The cache never legitimately asks for size 3; treat it as a word fetch
    // rather than emitting a reserved AXI size.
    function automatic logic [1:0] legal_size(input logic [1:0] size);
        legal_size = (size == 2'd3) ? AXI_SIZE_WORD[1:0] : size;
    endfunction

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Converts the I-cache sram-like read port into a single-outstanding,
// single-beat AXI4 read master (AR + R channels only).
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    output logic [31:0]     inst_rdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,
    output logic            bus_err,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready
);

    rd_state_t  state;
    logic [1:0] size_q;
    logic       ar_fire;
    logic       r_beat;
    logic       r_done;

    assign arid    = AXI_ID;
    assign arlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign arsize  = {1'b0, size_q};

    // Handshake decode; beats carrying a foreign RID are invisible to us.
    always_comb begin
        ar_fire = (state == ST_AR) && arvalid && arready;
        r_beat  = (state == ST_R) && rready && rvalid && (rid == AXI_ID);
        r_done  = r_beat && rlast;
    end

    // Cache-side responses are combinational so addr_ok/data_ok land in the handshake cycle.
    always_comb begin
        inst_addr_ok = ar_fire;
        inst_data_ok = r_done;
        inst_rdata   = r_done ? rdata : 32'h0;
        bus_err      = r_done && (rresp != AXI_RESP_OKAY);
    end

    // Request FSM with registered AR/R channel controls and address capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            araddr  <= 32'h0;
            size_q  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inst_req) begin
                        araddr  <= inst_addr;
                        size_q  <= legal_size(inst_size);
                        arvalid <= 1'b1;
                        state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    // araddr/size_q are only written in IDLE, so they hold while stalled.
                    if (ar_fire) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_R;
                    end
                end
                ST_R: begin
                    // A non-last beat is a protocol violation for arlen=0; swallow it and keep waiting.
                    if (r_done) begin
                        rready <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
